// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART serialiser.
// Bytes arrive over a valid/ready strobe. Each byte is sent as one frame: a
// start bit (0), 8 data bits LSB first, then a stop bit (1).
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is added after data bit 7, which makes the frame 8E1. By default the frame is 8N1.
// The line outputs (serial, active, done) are registered one cycle behind the
// FSM state. As a result, o_TX_Active and o_TX_Done line up with what is actually on the wire.
module uart_tx_fifo #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             ready_reg;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // The write decision looks only at the registered ready flag.
  // Because of this, a pop in the same cycle never frees a slot for a write to a full FIFO.
  assign push       = i_TX_DV && ready_reg;
  assign fifo_empty = (count_reg == '0);

  // Occupancy update: a push and a pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer, count and ready registers. Reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      ready_reg <= (count_next != FIFO_FULL);
    end
  end

  // Storage array. It has no reset so that it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= i_TX_Byte;
  end

  // Registered read: the head entry moves into the shift register on a pop.
  logic [7:0] tx_data_reg;
  always_ff @(posedge clk) begin
    if (pop) tx_data_reg <= mem_reg[rd_ptr_reg];
  end

  // ---------------------------------------------------------- serialiser
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] clk_count_reg;
  logic [CNT_W-1:0] clk_count_next;
  logic [2:0]       bit_index_reg;
  logic [2:0]       bit_index_next;
  logic             serial_reg;
  logic             serial_next;
  logic             active_reg;
  logic             active_next;
  logic             stop_last_reg;
  logic             stop_last_next;
  logic             done_reg;
  logic             bit_last;

  assign bit_last = (clk_count_reg == CNT_LAST);

  // Next-state, bit timing and line value. The line value is registered below.
  always_comb begin
    state_next     = state_reg;
    clk_count_next = clk_count_reg;
    bit_index_next = bit_index_reg;
    pop            = 1'b0;
    serial_next    = 1'b1;
    active_next    = 1'b1;
    stop_last_next = 1'b0;
    case (state_reg)
      IDLE: begin
        active_next    = 1'b0;
        clk_count_next = '0;
        bit_index_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START_BIT;
        end
      end
      START_BIT: begin
        serial_next = 1'b0;
        if (bit_last) begin
          clk_count_next = '0;
          state_next     = DATA_BITS;
        end else begin
          clk_count_next = clk_count_reg + 1'b1;
        end
      end
      DATA_BITS: begin
        serial_next = tx_data_reg[bit_index_reg];
        if (bit_last) begin
          clk_count_next = '0;
          if (bit_index_reg == 3'd7) begin
            bit_index_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next     = PARITY_BIT;
`else
            state_next     = STOP_BIT;
`endif
          end else begin
            bit_index_next = bit_index_reg + 1'b1;
          end
        end else begin
          clk_count_next = clk_count_reg + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        serial_next = ^tx_data_reg;
        if (bit_last) begin
          clk_count_next = '0;
          state_next     = STOP_BIT;
        end else begin
          clk_count_next = clk_count_reg + 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        serial_next = 1'b1;
        if (bit_last) begin
          clk_count_next = '0;
          stop_last_next = 1'b1;
          // Start the next queued frame straight away, with no idle gap between frames.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START_BIT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_count_next = clk_count_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and line registers. Reset mid-frame drops the frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      clk_count_reg <= '0;
      bit_index_reg <= '0;
      serial_reg    <= 1'b1;
      active_reg    <= 1'b0;
      stop_last_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_count_reg <= clk_count_next;
      bit_index_reg <= bit_index_next;
      serial_reg    <= serial_next;
      active_reg    <= active_next;
      stop_last_reg <= stop_last_next;
      // Done goes high in the cycle right after the stop bit has fully left the line.
      done_reg      <= stop_last_reg;
    end
  end

  assign o_TX_Ready  = ready_reg;
  assign o_TX_Serial = serial_reg;
  assign o_TX_Active = active_reg;
  assign o_TX_Done   = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Settings: CLKS_PER_BIT=10, FIFO_DEPTH=4.
// A line monitor decodes frames and records done pulses. The expected values are hand-computed.
module tb_uart_tx_fifo;

  localparam int CLKS = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic       o_TX_Ready;
  logic       o_TX_Serial;
  logic       o_TX_Active;
  logic       o_TX_Done;

  uart_tx_fifo #(
    .FPGA_clk_freq(1000000),
    .baudrate     (100000),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_TX_DV    (i_TX_DV),
    .i_TX_Byte  (i_TX_Byte),
    .o_TX_Ready (o_TX_Ready),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Active(o_TX_Active),
    .o_TX_Done  (o_TX_Done)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far. One nanosecond after edge k, cyc equals k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------ line monitor
  typedef struct {
    logic [7:0]  data;
    logic [10:0] raw;
    int          start;
    int          glitch;
    int          act_low;
  } frame_t;

  frame_t      frames[$];
  int          dones[$];
  frame_t      mon_f;
  logic        mon_busy = 1'b0;
  int          mon_cnt = 0;
  int          mon_bit = 0;
  int          mon_start = 0;
  int          mon_glitch = 0;
  int          mon_act = 0;
  logic [10:0] mon_raw = '0;

  // Samples the line on the falling edge. Every bit must hold its value for all CLKS cycles.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else begin
      if (o_TX_Done === 1'b1) dones.push_back(cyc);
      if (!mon_busy && o_TX_Serial === 1'b0) begin
        mon_busy   = 1'b1;
        mon_cnt    = 0;
        mon_start  = cyc;
        mon_glitch = 0;
        mon_act    = 0;
        mon_raw    = '0;
      end
      if (mon_busy) begin
        mon_bit = mon_cnt / CLKS;
        if (mon_cnt % CLKS == 0) mon_raw[mon_bit] = o_TX_Serial;
        else if (o_TX_Serial !== mon_raw[mon_bit]) mon_glitch++;
        if (o_TX_Active !== 1'b1) mon_act++;
        if (mon_cnt == FL - 1) begin
          mon_f.data    = mon_raw[8:1];
          mon_f.raw     = mon_raw;
          mon_f.start   = mon_start;
          mon_f.glitch  = mon_glitch;
          mon_f.act_low = mon_act;
          frames.push_back(mon_f);
          $display("rx frame: byte 0x%02h raw 0x%03h start cycle %0d", mon_f.data, mon_f.raw, mon_f.start);
          mon_busy = 1'b0;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  // ------------------------------------------------------ helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    acc       = o_TX_Ready;
    i_TX_DV   = 1'b1;
    i_TX_Byte = b;
    tick();
    i_TX_DV   = 1'b0;
    i_TX_Byte = 8'hEE;
    $display("tx write: byte 0x%02h at cycle %0d ready %0d", b, cyc, acc);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] exp_data, input int exp_start);
    if (idx < frames.size()) begin
      check_value({tag, "_data"},   32'(frames[idx].data), 32'(exp_data));
      check_value({tag, "_start"},  frames[idx].start, exp_start);
      check_value({tag, "_glitch"}, frames[idx].glitch, 0);
      check_value({tag, "_active"}, frames[idx].act_low, 0);
      check_value({tag, "_stop"},   32'(frames[idx].raw[NB-1]), 1);
    end else begin
      check_value({tag, "_missing"}, frames.size(), idx + 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------ stimulus
  logic [7:0] t3_bytes [5];
  logic [7:0] t5_bytes [4];
  int n;
  int w;
  int lows;

  initial begin
    t3_bytes[0] = 8'h00; t3_bytes[1] = 8'hFF; t3_bytes[2] = 8'h55;
    t3_bytes[3] = 8'h0F; t3_bytes[4] = 8'h81;
    t5_bytes[0] = 8'h00; t5_bytes[1] = 8'hFF; t5_bytes[2] = 8'h5A; t5_bytes[3] = 8'hC3;

    // 1: reset state, then the line stays idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_value("rst_serial", 32'(o_TX_Serial), 1);
    check_value("rst_ready",  32'(o_TX_Ready),  1);
    check_value("rst_active", 32'(o_TX_Active), 0);
    check_value("rst_done",   32'(o_TX_Done),   0);
    lows = 0;
    repeat (50) begin
      tick();
      if (o_TX_Serial !== 1'b1) lows++;
    end
    check_value("idle_line_lows", lows, 0);

    // 2: single byte 0xA5, check latency and done timing
    frames.delete(); dones.delete();
    send(8'hA5);
    n = cyc;
    tick();
    check_value("t2_line_n1",   32'(o_TX_Serial), 1);
    check_value("t2_active_n1", 32'(o_TX_Active), 0);
    while (cyc < n + FL + 2) tick();
    check_value("t2_done_pulse",  32'(o_TX_Done),   1);
    check_value("t2_active_end",  32'(o_TX_Active), 0);
    check_value("t2_line_end",    32'(o_TX_Serial), 1);
    tick();
    check_value("t2_done_clear",  32'(o_TX_Done), 0);
    check_frame("t2", 0, 8'hA5, n + 2);
    if (frames.size() > 0) begin
`ifdef UART_TX_PARITY_EN
      check_value("t2_raw", 32'(frames[0].raw), 32'h54A);
`else
      check_value("t2_raw", 32'(frames[0].raw), 32'h34A);
`endif
    end
    check_value("t2_done_count", dones.size(), 1);
    if (dones.size() > 0) check_value("t2_done_cycle", dones[0], n + FL + 2);

    // 3: burst of five writes, then a sixth write while the FIFO is full
    frames.delete(); dones.delete();
    i_TX_DV = 1'b1;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      i_TX_Byte = t3_bytes[i];
      tick();
      if (i == 0) w = cyc;
      $display("tx write: byte 0x%02h at cycle %0d", t3_bytes[i], cyc);
    end
    check_value("t3_ready_full", 32'(o_TX_Ready), 0);
    i_TX_Byte = 8'h99;
    tick();
    $display("tx write: byte 0x99 at cycle %0d while full", cyc);
    i_TX_DV   = 1'b0;
    i_TX_Byte = 8'hEE;
    check_value("t3_ready_still_full", 32'(o_TX_Ready), 0);
    wait_frames(5, 700);
    repeat (150) tick();
    check_value("t3_frame_count", frames.size(), 5);
    for (int i = 0; i < 5; i++) check_frame($sformatf("t3_f%0d", i), i, t3_bytes[i], w + 2 + i * FL);
    check_value("t3_done_count", dones.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < dones.size()) check_value($sformatf("t3_done%0d", i), dones[i], w + 2 + (i + 1) * FL);
    check_value("t3_ready_back", 32'(o_TX_Ready), 1);

    // 4: reset in the middle of data bit 3 of 0x3C, then send a clean frame
    frames.delete(); dones.delete();
    send(8'h3C);
    n = cyc;
    while (cyc < n + 2 + 44) tick();
    rst = 1'b1;
    tick();
    check_value("t4_line_high", 32'(o_TX_Serial), 1);
    check_value("t4_active",    32'(o_TX_Active), 0);
    check_value("t4_done",      32'(o_TX_Done),   0);
    check_value("t4_ready",     32'(o_TX_Ready),  1);
    rst = 1'b0;
    repeat (120) tick();
    check_value("t4_no_frame", frames.size(), 0);
    check_value("t4_no_done",  dones.size(),  0);
    send(8'h12);
    n = cyc;
    wait_frames(1, 300);
    repeat (5) tick();
    check_frame("t4_after", 0, 8'h12, n + 2);
    check_value("t4_after_done_count", dones.size(), 1);
    if (dones.size() > 0) check_value("t4_after_done_cycle", dones[0], n + 2 + FL);

    // 5: loopback through the line monitor
    frames.delete(); dones.delete();
    i_TX_DV = 1'b1;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      i_TX_Byte = t5_bytes[i];
      tick();
      if (i == 0) w = cyc;
      $display("tx write: byte 0x%02h at cycle %0d", t5_bytes[i], cyc);
    end
    i_TX_DV = 1'b0;
    wait_frames(4, 600);
    repeat (20) tick();
    check_value("t5_frame_count", frames.size(), 4);
    for (int i = 0; i < 4; i++) check_frame($sformatf("t5_f%0d", i), i, t5_bytes[i], w + 2 + i * FL);
    check_value("t5_done_count", dones.size(), 4);

`ifdef UART_TX_PARITY_EN
    // 6: even parity bit on the line
    frames.delete(); dones.delete();
    send(8'h07);
    wait_frames(1, 300);
    repeat (5) tick();
    if (frames.size() > 0) begin
      check_value("t6_raw_07", 32'(frames[0].raw), 32'h60E);
      if (dones.size() > 0) check_value("t6_len_07", dones[0] - frames[0].start, 110);
    end
    check_value("t6_count_07", frames.size(), 1);
    frames.delete(); dones.delete();
    send(8'h03);
    wait_frames(1, 300);
    repeat (5) tick();
    check_value("t6_count_03", frames.size(), 1);
    if (frames.size() > 0) check_value("t6_raw_03", 32'(frames[0].raw), 32'h406);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
